// File: rtl/bridge_pkg.sv
// ---------------------------------------------------------------------------
// bridge_pkg
// Purpose : Shared constants and helpers for the 1-master/N-slave data bridge.
//           The XLEN macro is defined here (32 by default) so that every
//           later file of the bridge sees the same data/address width.
// Ports   : none (package)
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

package bridge_pkg;

  localparam int NSLV_DEFAULT = 4;

  // One extra code beyond the slave indices is reserved for the bridge's own
  // decode-error responder, so the ID width covers 0..NSLV.
  function automatic int slvIdWidth(input int nslv);
    return $clog2(nslv + 1);
  endfunction

  localparam int SLV_ID_W = $clog2(NSLV_DEFAULT + 1);

  localparam logic [31:0] DECERR_RDATA = 32'hDEAD_BEEF;

  // Default address window of the confreg slave.
  localparam logic [31:0] CONF_BASE = 32'h1faf_0000;
  localparam logic [31:0] CONF_MASK = 32'h1fff_0000;

endpackage

// File: rtl/bridge_1xn_if.sv
// ---------------------------------------------------------------------------
// bridge_1xn_if
// Purpose : Groups the CPU-side split handshake and the broadcast slave-side
//           bus of bridge_1xn into one bundle.
// Modports: slave  - view of the bridge (CPU requests in, slave replies in,
//                    CPU replies out, slave requests out)
//           master - view of the surrounding CPU and slaves (the opposite)
// Signals : cpu_req/wr/size/wstrb/addr/wdata, cpu_addr_ok/data_ok/rdata,
//           slv_req[NSLV], slv_wr/size/wstrb/addr/wdata, slv_addr_ok[NSLV],
//           slv_data_ok[NSLV], slv_rdata[NSLV*XLEN], decerr
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

interface bridge_1xn_if #(
  parameter int NSLV = 4
);

  logic                   cpu_req;
  logic                   cpu_wr;
  logic [1:0]             cpu_size;
  logic [3:0]             cpu_wstrb;
  logic [`XLEN-1:0]       cpu_addr;
  logic [`XLEN-1:0]       cpu_wdata;
  logic                   cpu_addr_ok;
  logic                   cpu_data_ok;
  logic [`XLEN-1:0]       cpu_rdata;

  logic [NSLV-1:0]        slv_req;
  logic                   slv_wr;
  logic [1:0]             slv_size;
  logic [3:0]             slv_wstrb;
  logic [`XLEN-1:0]       slv_addr;
  logic [`XLEN-1:0]       slv_wdata;
  logic [NSLV-1:0]        slv_addr_ok;
  logic [NSLV-1:0]        slv_data_ok;
  logic [NSLV*`XLEN-1:0]  slv_rdata;

  logic                   decerr;

  modport slave (
    input  cpu_req, cpu_wr, cpu_size, cpu_wstrb, cpu_addr, cpu_wdata,
    output cpu_addr_ok, cpu_data_ok, cpu_rdata,
    output slv_req, slv_wr, slv_size, slv_wstrb, slv_addr, slv_wdata,
    input  slv_addr_ok, slv_data_ok, slv_rdata,
    output decerr
  );

  modport master (
    output cpu_req, cpu_wr, cpu_size, cpu_wstrb, cpu_addr, cpu_wdata,
    input  cpu_addr_ok, cpu_data_ok, cpu_rdata,
    input  slv_req, slv_wr, slv_size, slv_wstrb, slv_addr, slv_wdata,
    output slv_addr_ok, slv_data_ok, slv_rdata,
    input  decerr
  );

endinterface

// File: rtl/bridge_id_fifo.sv
// ---------------------------------------------------------------------------
// bridge_id_fifo
// Purpose : In-order FIFO of target IDs for accepted-but-unanswered
//           transactions. The head tells the bridge which slave owes the
//           next response.
// Ports   : clk, reset (synchronous, active-high)
//           push_i/data_i - enqueue one ID
//           pop_i         - dequeue the head
//           head_o        - ID at the head (valid while cnt_o != 0)
//           cnt_o         - number of stored IDs (0..DEPTH)
//           full_o        - cnt_o == DEPTH
// The caller never pushes when full nor pops when empty.
// ---------------------------------------------------------------------------
module bridge_id_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o
);

  localparam int PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem [DEPTH];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  assign wrPtr_d = wrPtr_q + PtrW'(1);
  assign rdPtr_d = rdPtr_q + PtrW'(1);
  assign cnt_d   = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);

  sirv_gnrl_dfflr #(.DW(PtrW)) u_wrPtr (
    .lden(push_i), .dnxt(wrPtr_d), .qout(wrPtr_q), .clk(clk), .rst(reset));

  sirv_gnrl_dfflr #(.DW(PtrW)) u_rdPtr (
    .lden(pop_i), .dnxt(rdPtr_d), .qout(rdPtr_q), .clk(clk), .rst(reset));

  // A simultaneous push and pop leaves the count untouched.
  sirv_gnrl_dfflr #(.DW(CNT_W)) u_cnt (
    .lden(push_i ^ pop_i), .dnxt(cnt_d), .qout(cnt_q), .clk(clk), .rst(reset));

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    sirv_gnrl_dfflr #(.DW(WIDTH)) u_ent (
      .lden(push_i && (wrPtr_q == PtrW'(g))),
      .dnxt(data_i),
      .qout(mem[g]),
      .clk(clk),
      .rst(reset)
    );
  end

  assign head_o = mem[rdPtr_q];
  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_dfflr
// Purpose : Generic load-enabled flop vector with synchronous active-high
//           reset to zero. All bridge state is held in these cells.
// Ports   : lden (load enable), dnxt (next value), qout (current value),
//           clk, rst (synchronous, active-high)
// ---------------------------------------------------------------------------
module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst
);

  logic [DW-1:0] qout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      qout_q <= '0;
    end else if (lden) begin
      qout_q <= dnxt;
    end
  end

  assign qout = qout_q;

endmodule

// File: rtl/bridge_1xn.sv
// ---------------------------------------------------------------------------
// bridge_1xn
// Purpose : Routes one CPU data port (req/addr_ok/data_ok split handshake)
//           to NSLV slaves selected by base/mask address windows, allowing
//           up to OUTST_DEPTH outstanding transactions and returning the
//           responses in issue order. Slave 0 is the default slave.
// Ports   : clk   - clock
//           reset - synchronous, active-high reset (shared with slaves)
//           bus   - bridge_1xn_if.slave (CPU side, slave side, decerr)
// Options : BRIDGE_DECERR_EN - when defined, addresses that hit no window
//           are answered by the bridge itself with rdata 32'hDEAD_BEEF and
//           a decerr pulse instead of going to slave 0.
// ---------------------------------------------------------------------------
module bridge_1xn
  import bridge_pkg::*;
#(
  parameter int                    NSLV        = 4,
  parameter int                    OUTST_DEPTH = 4,
  parameter logic [NSLV*`XLEN-1:0] SLV_BASE    = {NSLV{32'h0}},
  parameter logic [NSLV*`XLEN-1:0] SLV_MASK    = {NSLV{32'h0}}
) (
  input logic          clk,
  input logic          reset,
  bridge_1xn_if.slave  bus
);

  localparam int XL   = `XLEN;
  localparam int IdW  = slvIdWidth(NSLV);
  localparam int CntW = $clog2(OUTST_DEPTH) + 1;
  localparam logic [IdW-1:0] ErrId = IdW'(NSLV);

  logic [IdW-1:0]  tgt;
  logic [IdW-1:0]  head;
  logic [IdW-1:0]  lastTgt_q;
  logic [CntW-1:0] cnt;
  logic            full;
  logic            allow;
  logic            isErrTgt;
  logic            tgtAddrOk;
  logic            headDataOk;
  logic            errResp;
  logic            push;
  logic            pop;
  logic [NSLV-1:0] tgtSel;
  logic [NSLV-1:0] headSel;
  logic [XL-1:0]   headRdata;

  // Scan from the top down so the lowest matching window wins. Entry 0 is
  // never matched; it only receives what nothing else claims.
  always_comb begin
`ifdef BRIDGE_DECERR_EN
    tgt = ErrId;
`else
    tgt = '0;
`endif
    for (int i = NSLV - 1; i >= 1; i--) begin
      if ((bus.cpu_addr & SLV_MASK[i*XL +: XL]) == SLV_BASE[i*XL +: XL]) begin
        tgt = IdW'(i);
      end
    end
    isErrTgt = (tgt == ErrId);
  end

  // One-hot views of the target and the head. The head view is empty while
  // nothing is outstanding, which masks any stray slave response.
  always_comb begin
    tgtSel     = '0;
    headSel    = '0;
    tgtAddrOk  = 1'b0;
    headDataOk = 1'b0;
    headRdata  = '0;
    for (int i = 0; i < NSLV; i++) begin
      tgtSel[i]  = (tgt == IdW'(i));
      headSel[i] = (cnt != '0) && (head == IdW'(i));
      tgtAddrOk  = tgtAddrOk | (tgtSel[i] & bus.slv_addr_ok[i]);
      if (headSel[i] && bus.slv_data_ok[i]) begin
        headDataOk = 1'b1;
        headRdata  = bus.slv_rdata[i*XL +: XL];
      end
    end
  end

  // Switching to a different target is only allowed once everything in
  // flight has returned; this is what keeps responses in order.
  assign allow = !full && ((cnt == '0) || (tgt == lastTgt_q));

  assign bus.slv_req     = (bus.cpu_req && allow) ? tgtSel : '0;
  assign bus.cpu_addr_ok = bus.cpu_req && allow && (isErrTgt || tgtAddrOk);
  assign push            = bus.cpu_req && bus.cpu_addr_ok;

  // The decode-error responder answers as soon as its ID sits at the head of
  // a non-empty FIFO, i.e. at the earliest one cycle after acceptance.
`ifdef BRIDGE_DECERR_EN
  assign errResp = (cnt != '0) && (head == ErrId);
`else
  assign errResp = 1'b0;
`endif

  assign bus.cpu_data_ok = headDataOk || errResp;
  assign bus.cpu_rdata   = errResp ? DECERR_RDATA : headRdata;
  assign bus.decerr      = errResp;
  assign pop             = bus.cpu_data_ok;

  assign bus.slv_wr    = bus.cpu_wr;
  assign bus.slv_size  = bus.cpu_size;
  assign bus.slv_wstrb = bus.cpu_wstrb;
  assign bus.slv_addr  = bus.cpu_addr;
  assign bus.slv_wdata = bus.cpu_wdata;

  sirv_gnrl_dfflr #(.DW(IdW)) u_lastTgt (
    .lden(push), .dnxt(tgt), .qout(lastTgt_q), .clk(clk), .rst(reset));

  bridge_id_fifo #(
    .WIDTH(IdW),
    .DEPTH(OUTST_DEPTH),
    .CNT_W(CntW)
  ) u_idFifo (
    .clk(clk),
    .reset(reset),
    .push_i(push),
    .pop_i(pop),
    .data_i(tgt),
    .head_o(head),
    .cnt_o(cnt),
    .full_o(full)
  );

  // A slave may only answer when it owns the head of the queue.
  assert property (@(posedge clk) disable iff (reset)
                   (bus.slv_data_ok & ~headSel) == '0);

endmodule

// File: tb/tb_bridge_1xn.sv
// ---------------------------------------------------------------------------
// tb_bridge_1xn
// Purpose : Directed self-checking bench for bridge_1xn with two slaves:
//           slave 0 default, slave 1 on the confreg window. Honours
//           BRIDGE_DECERR_EN for the unmatched-address case.
// ---------------------------------------------------------------------------
module tb_bridge_1xn;
  import bridge_pkg::*;

  localparam int NSLV  = 2;
  localparam int DEPTH = 4;
  localparam logic [NSLV*32-1:0] BASE = {CONF_BASE, 32'h0};
  localparam logic [NSLV*32-1:0] MASK = {CONF_MASK, 32'h0};

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  bridge_1xn_if #(.NSLV(NSLV)) bus ();

  bridge_1xn #(
    .NSLV(NSLV),
    .OUTST_DEPTH(DEPTH),
    .SLV_BASE(BASE),
    .SLV_MASK(MASK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  // Single comparison point: counts every vector and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs just after the clock edge and returns at the
  // following falling edge, where the combinational outputs are settled.
  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic [1:0] addrOk, input logic [1:0] dataOk,
                               input logic [31:0] rd0, input logic [31:0] rd1);
    @(posedge clk);
    #1;
    bus.cpu_req     = req;
    bus.cpu_addr    = addr;
    bus.slv_addr_ok = addrOk;
    bus.slv_data_ok = dataOk;
    bus.slv_rdata   = {rd1, rd0};
    @(negedge clk);
  endtask

  // Compares the full set of bridge outputs against hand-computed values.
  task automatic expectBus(input string tag, input logic aok, input logic dok,
                           input logic [1:0] sreq, input logic [31:0] rdata,
                           input logic derr);
    checkOutput({tag, " addr_ok"}, 64'(bus.cpu_addr_ok), 64'(aok));
    checkOutput({tag, " data_ok"}, 64'(bus.cpu_data_ok), 64'(dok));
    checkOutput({tag, " slv_req"}, 64'(bus.slv_req), 64'(sreq));
    checkOutput({tag, " rdata"},   64'(bus.cpu_rdata), 64'(rdata));
    checkOutput({tag, " decerr"},  64'(bus.decerr), 64'(derr));
  endtask

  // Directed sequence: routing, fill/stall, ordering, push+pop, reset, decerr.
  initial begin
    bus.cpu_req     = 1'b0;
    bus.cpu_wr      = 1'b0;
    bus.cpu_size    = 2'd2;
    bus.cpu_wstrb   = 4'hF;
    bus.cpu_addr    = '0;
    bus.cpu_wdata   = 32'h1234_5678;
    bus.slv_addr_ok = '0;
    bus.slv_data_ok = '0;
    bus.slv_rdata   = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    expectBus("reset", 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Window routing and zero-latency response path.
    applyStimulus(1'b1, 32'h1faf_f020, 2'b10, 2'b00, 32'h5555_aaaa, 32'h1111_2222);
    expectBus("conf issue", 1'b1, 1'b0, 2'b10, 32'h0, 1'b0);
    checkOutput("bcast addr", 64'(bus.slv_addr), 64'h1faf_f020);
    checkOutput("bcast wdata", 64'(bus.slv_wdata), 64'h1234_5678);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b10, 32'h5555_aaaa, 32'h1111_2222);
    expectBus("conf resp", 1'b0, 1'b1, 2'b00, 32'h1111_2222, 1'b0);
    applyStimulus(1'b1, 32'h0000_1000, 2'b01, 2'b00, 32'h0, 32'h0);
    expectBus("dflt issue", 1'b1, 1'b0, 2'b01, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b01, 32'hA0A0_0001, 32'h0);
    expectBus("dflt resp", 1'b0, 1'b1, 2'b00, 32'hA0A0_0001, 1'b0);

    // Fill to OUTST_DEPTH, stall, pop does not unblock until next cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * k), 2'b01, 2'b00, 32'h0, 32'h0);
      expectBus("fill", 1'b1, 1'b0, 2'b01, 32'h0, 1'b0);
    end
    applyStimulus(1'b1, 32'h200, 2'b01, 2'b00, 32'h0, 32'h0);
    expectBus("full stall", 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h200, 2'b01, 2'b01, 32'hB000_0000, 32'h0);
    expectBus("full pop", 1'b0, 1'b1, 2'b00, 32'hB000_0000, 1'b0);
    applyStimulus(1'b1, 32'h200, 2'b01, 2'b00, 32'h0, 32'h0);
    expectBus("after pop", 1'b1, 1'b0, 2'b01, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 2'b00, 2'b01, 32'hB000_0001 + 32'(k), 32'h0);
      expectBus("drain", 1'b0, 1'b1, 2'b00, 32'hB000_0001 + 32'(k), 1'b0);
    end

    // No slave switch while a response is pending.
    applyStimulus(1'b1, 32'h300, 2'b01, 2'b00, 32'h0, 32'h0);
    expectBus("ord s0", 1'b1, 1'b0, 2'b01, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h1faf_0004, 2'b11, 2'b00, 32'h0, 32'h0);
    expectBus("ord block", 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h1faf_0004, 2'b11, 2'b01, 32'hC000_0000, 32'h0);
    expectBus("ord s0 resp", 1'b0, 1'b1, 2'b00, 32'hC000_0000, 1'b0);
    applyStimulus(1'b1, 32'h1faf_0004, 2'b11, 2'b00, 32'h0, 32'h0);
    expectBus("ord s1 go", 1'b1, 1'b0, 2'b10, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b10, 32'h0, 32'hC000_0001);
    expectBus("ord s1 resp", 1'b0, 1'b1, 2'b00, 32'hC000_0001, 1'b0);

    // Push and pop together at cnt=2, then in-order responses.
    applyStimulus(1'b1, 32'h1faf_0010, 2'b10, 2'b00, 32'h0, 32'h0);
    expectBus("pp push1", 1'b1, 1'b0, 2'b10, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h1faf_0014, 2'b10, 2'b00, 32'h0, 32'h0);
    expectBus("pp push2", 1'b1, 1'b0, 2'b10, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h1faf_0018, 2'b10, 2'b10, 32'h0, 32'hD000_0001);
    expectBus("pp both", 1'b1, 1'b1, 2'b10, 32'hD000_0001, 1'b0);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b10, 32'h0, 32'hD000_0002);
    expectBus("pp resp2", 1'b0, 1'b1, 2'b00, 32'hD000_0002, 1'b0);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b10, 32'h0, 32'hD000_0003);
    expectBus("pp resp3", 1'b0, 1'b1, 2'b00, 32'hD000_0003, 1'b0);
    applyStimulus(1'b1, 32'h400, 2'b01, 2'b00, 32'h0, 32'h0);
    expectBus("pp empty", 1'b1, 1'b0, 2'b01, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b01, 32'hD000_0004, 32'h0);
    expectBus("pp resp4", 1'b0, 1'b1, 2'b00, 32'hD000_0004, 1'b0);

    // Reset with three transactions outstanding to slave 1.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h1faf_0020 + 32'(4 * k), 2'b10, 2'b00, 32'h0, 32'h0);
      expectBus("rst fill", 1'b1, 1'b0, 2'b10, 32'h0, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.cpu_req     = 1'b0;
    bus.slv_addr_ok = '0;
    bus.slv_data_ok = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    expectBus("post rst", 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h500, 2'b01, 2'b00, 32'h0, 32'h0);
    expectBus("post rst issue", 1'b1, 1'b0, 2'b01, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b01, 32'hE000_0005, 32'h0);
    expectBus("post rst resp", 1'b0, 1'b1, 2'b00, 32'hE000_0005, 1'b0);

    // Address outside every window.
`ifdef BRIDGE_DECERR_EN
    applyStimulus(1'b1, 32'h8000_0000, 2'b00, 2'b00, 32'h0, 32'h0);
    expectBus("decerr issue", 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    expectBus("decerr resp", 1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF, 1'b1);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    expectBus("decerr done", 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
`else
    applyStimulus(1'b1, 32'h8000_0000, 2'b01, 2'b00, 32'h0, 32'h0);
    expectBus("miss issue", 1'b1, 1'b0, 2'b01, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b01, 32'hF000_0000, 32'h0);
    expectBus("miss resp", 1'b0, 1'b1, 2'b00, 32'hF000_0000, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
